// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT0 write-block serializer.
//  sd_dat_state_e  : serializer FSM states
//  SD_START_BIT / SD_END_BIT : framing bit values on DAT0
//  SD_CRC16_W / SD_CRC16_POLY : CRC-16 (x^16+x^12+x^5+1) width and polynomial
//  crc16_step()    : one serial CRC-16 update
package sd_dat_pkg;

    localparam int unsigned SD_BYTE_W    = 8;
    localparam int unsigned SD_BIT_CNT_W = 3;
    localparam int unsigned SD_CRC_CNT_W = 4;
    localparam int unsigned SD_CRC16_W   = 16;

    localparam logic                  SD_START_BIT  = 1'b0;
    localparam logic                  SD_END_BIT    = 1'b1;
    localparam logic [SD_CRC16_W-1:0] SD_CRC16_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CRC   = 3'd3,
        ST_END   = 3'd4
    } sd_dat_state_e;

    // Serial CRC-16 update: feedback is the incoming bit xor the current MSB.
    function automatic logic [SD_CRC16_W-1:0] crc16_step(
        input logic [SD_CRC16_W-1:0] crc,
        input logic                  bitval
    );
        logic fb;
        fb = bitval ^ crc[SD_CRC16_W-1];
        return {crc[SD_CRC16_W-2:0], 1'b0} ^ (fb ? SD_CRC16_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_dat_blk_tx_if.sv
// Byte-input / DAT0-output bundle of the SD write-block serializer.
//  master : write-FIFO / controller side (drives bit_en, start, din, din_valid[, crc_inj])
//  slave  : serializer side (drives din_ready, dat_out, dat_oe, clk_hold, busy, done)
// Optional: SD_DAT_TX_CRC_INJ_EN adds crc_inj (invert CRC bit 0 of the next block).
interface sd_dat_blk_tx_if;
    import sd_dat_pkg::*;

    logic                 bit_en;
    logic                 start;
    logic [SD_BYTE_W-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic                 dat_out;
    logic                 dat_oe;
    logic                 clk_hold;
    logic                 busy;
    logic                 done;
`ifdef SD_DAT_TX_CRC_INJ_EN
    logic                 crc_inj;
`endif

    modport master (
`ifdef SD_DAT_TX_CRC_INJ_EN
        output crc_inj,
`endif
        output bit_en, start, din, din_valid,
        input  din_ready, dat_out, dat_oe, clk_hold, busy, done
    );

    modport slave (
`ifdef SD_DAT_TX_CRC_INJ_EN
        input  crc_inj,
`endif
        input  bit_en, start, din, din_valid,
        output din_ready, dat_out, dat_oe, clk_hold, busy, done
    );

endinterface

// File: rtl/sd_crc_16.sv
// Serial CRC-16 (x^16+x^12+x^5+1), initial value 0, one bit per enabled CLK.
//  CLK    in  clock
//  RST    in  asynchronous active-high clear
//  Enable in  shift BITVAL into the CRC this cycle
//  BITVAL in  data bit
//  CRC    out current CRC value (registered)
module sd_crc_16
    import sd_dat_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Enable,
    input  logic                  BITVAL,
    output logic [SD_CRC16_W-1:0] CRC
);

    logic [SD_CRC16_W-1:0] crc_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            crc_q <= '0;
        end else if (Enable) begin
            crc_q <= crc16_step(crc_q, BITVAL);
        end
    end

    assign CRC = crc_q;

endmodule

// File: rtl/sd_dat_blk_tx.sv
// Host-side SD DAT0 write-block serializer (1-bit bus). Sends start bit, BLK_BYTES
// bytes MSB-first, CRC-16 MSB-first and end bit, one bit per bit_en strobe.
//  CLK, RST (async, active-high)
//  bus (slave): bit_en, start, din, din_valid -> din_ready, dat_out, dat_oe,
//               clk_hold, busy, done (all registered)
// Optional: SD_DAT_TX_CRC_INJ_EN adds bus.crc_inj; when set at start, CRC bit 0
// is inverted on the wire.
module sd_dat_blk_tx
    import sd_dat_pkg::*;
#(
    parameter int unsigned BLK_BYTES = 512,
    parameter int unsigned CNT_W     = 12
) (
    input  logic           CLK,
    input  logic           RST,
    sd_dat_blk_tx_if.slave bus
);

    localparam logic [CNT_W-1:0] BLK_CNT = CNT_W'(BLK_BYTES);

    sd_dat_state_e               state_q, state_d;
    logic                        dat_out_q, dat_out_d;
    logic                        dat_oe_q, dat_oe_d;
    logic                        din_ready_q, din_ready_d;
    logic                        clk_hold_q, clk_hold_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        crc_clr_q, crc_clr_d;
    logic [SD_BYTE_W-1:0]        sr_q, sr_d;
    logic [SD_BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SD_BYTE_W-1:0]        hb_q, hb_d;
    logic                        hb_vld_q, hb_vld_d;
    logic [CNT_W-1:0]            tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]            acc_cnt_q, acc_cnt_d;
    logic [SD_CRC16_W-1:0]       crc_sh_q, crc_sh_d;
    logic [SD_CRC_CNT_W-1:0]     crc_cnt_q, crc_cnt_d;
    logic                        end_sent_q, end_sent_d;
`ifdef SD_DAT_TX_CRC_INJ_EN
    logic                        inj_q, inj_d;
`endif

    logic                        take_c;
    logic                        stall_c;
    logic                        bypass_c;
    logic                        crc_en_c;
    logic                        crc_bit_c;
    logic                        crc_rst_c;
    logic [SD_BYTE_W-1:0]        ld_byte_c;
    logic [SD_CRC16_W-1:0]       crc_val_c;
    logic [SD_CRC16_W-1:0]       crc_tx_c;

    // CRC engine is cleared for one cycle at the start of every block.
    assign crc_rst_c = RST | crc_clr_q;

    sd_crc_16 u_crc (
        .CLK    (CLK),
        .RST    (crc_rst_c),
        .Enable (crc_en_c),
        .BITVAL (crc_bit_c),
        .CRC    (crc_val_c)
    );

    // Value loaded into the CRC out-shifter (optionally with bit 0 flipped).
`ifdef SD_DAT_TX_CRC_INJ_EN
    assign crc_tx_c = crc_val_c ^ {{(SD_CRC16_W-1){1'b0}}, inj_q};
`else
    assign crc_tx_c = crc_val_c;
`endif

    // Next byte at a boundary comes from the holding buffer, else straight from din.
    assign ld_byte_c = hb_vld_q ? hb_q : bus.din;

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        dat_out_d   = dat_out_q;
        dat_oe_d    = dat_oe_q;
        din_ready_d = 1'b0;
        clk_hold_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        crc_clr_d   = 1'b0;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        hb_d        = hb_q;
        hb_vld_d    = hb_vld_q;
        tx_cnt_d    = tx_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        crc_sh_d    = crc_sh_q;
        crc_cnt_d   = crc_cnt_q;
        end_sent_d  = end_sent_q;
`ifdef SD_DAT_TX_CRC_INJ_EN
        inj_d       = inj_q;
`endif
        take_c      = bus.din_valid && din_ready_q;
        stall_c     = 1'b0;
        bypass_c    = 1'b0;
        crc_en_c    = 1'b0;
        crc_bit_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_START;
                    busy_d    = 1'b1;
                    crc_clr_d = 1'b1;
                    bit_cnt_d = '0;
                    hb_vld_d  = 1'b0;
                    tx_cnt_d  = '0;
                    acc_cnt_d = '0;
`ifdef SD_DAT_TX_CRC_INJ_EN
                    inj_d     = bus.crc_inj;
`endif
                end
            end

            ST_START: begin
                if (bus.bit_en) begin
                    dat_out_d = SD_START_BIT;
                    dat_oe_d  = 1'b1;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bus.bit_en) begin
                    if (bit_cnt_q != '0) begin
                        dat_out_d = sr_q[SD_BYTE_W-1];
                        sr_d      = {sr_q[SD_BYTE_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - SD_BIT_CNT_W'(1);
                        crc_en_c  = 1'b1;
                        crc_bit_c = sr_q[SD_BYTE_W-1];
                    end else if (tx_cnt_q == BLK_CNT) begin
                        // CRC is complete; first CRC bit goes out on this edge.
                        dat_out_d = crc_tx_c[SD_CRC16_W-1];
                        crc_sh_d  = {crc_tx_c[SD_CRC16_W-2:0], 1'b0};
                        crc_cnt_d = SD_CRC_CNT_W'(SD_CRC16_W - 1);
                        state_d   = ST_CRC;
                    end else if (hb_vld_q || take_c) begin
                        bypass_c  = !hb_vld_q;
                        dat_out_d = ld_byte_c[SD_BYTE_W-1];
                        sr_d      = {ld_byte_c[SD_BYTE_W-2:0], 1'b0};
                        bit_cnt_d = SD_BIT_CNT_W'(SD_BYTE_W - 1);
                        tx_cnt_d  = tx_cnt_q + CNT_W'(1);
                        hb_vld_d  = 1'b0;
                        crc_en_c  = 1'b1;
                        crc_bit_c = ld_byte_c[SD_BYTE_W-1];
                    end else begin
                        stall_c   = 1'b1;
                    end
                end
                if (take_c && !bypass_c) begin
                    hb_d     = bus.din;
                    hb_vld_d = 1'b1;
                end
                if (take_c) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
                // Hold stays up from the starved edge until a byte is accepted.
                clk_hold_d = stall_c || (clk_hold_q && !take_c);
            end

            ST_CRC: begin
                if (bus.bit_en) begin
                    dat_out_d = crc_sh_q[SD_CRC16_W-1];
                    crc_sh_d  = {crc_sh_q[SD_CRC16_W-2:0], 1'b0};
                    crc_cnt_d = crc_cnt_q - SD_CRC_CNT_W'(1);
                    if (crc_cnt_q == SD_CRC_CNT_W'(1)) begin
                        state_d    = ST_END;
                        end_sent_d = 1'b0;
                    end
                end
            end

            ST_END: begin
                if (bus.bit_en) begin
                    if (!end_sent_q) begin
                        dat_out_d  = SD_END_BIT;
                        end_sent_d = 1'b1;
                    end else begin
                        dat_oe_d  = 1'b0;
                        dat_out_d = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        din_ready_d = (state_d == ST_DATA) && !hb_vld_d && (acc_cnt_d != BLK_CNT);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            dat_out_q   <= 1'b1;
            dat_oe_q    <= 1'b0;
            din_ready_q <= 1'b0;
            clk_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_clr_q   <= 1'b0;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            hb_q        <= '0;
            hb_vld_q    <= 1'b0;
            tx_cnt_q    <= '0;
            acc_cnt_q   <= '0;
            crc_sh_q    <= '0;
            crc_cnt_q   <= '0;
            end_sent_q  <= 1'b0;
`ifdef SD_DAT_TX_CRC_INJ_EN
            inj_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dat_out_q   <= dat_out_d;
            dat_oe_q    <= dat_oe_d;
            din_ready_q <= din_ready_d;
            clk_hold_q  <= clk_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            crc_clr_q   <= crc_clr_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            hb_q        <= hb_d;
            hb_vld_q    <= hb_vld_d;
            tx_cnt_q    <= tx_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            crc_sh_q    <= crc_sh_d;
            crc_cnt_q   <= crc_cnt_d;
            end_sent_q  <= end_sent_d;
`ifdef SD_DAT_TX_CRC_INJ_EN
            inj_q       <= inj_d;
`endif
        end
    end

    assign bus.dat_out   = dat_out_q;
    assign bus.dat_oe    = dat_oe_q;
    assign bus.din_ready = din_ready_q;
    assign bus.clk_hold  = clk_hold_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sd_dat_blk_tx.sv
// Bench for sd_dat_blk_tx: drives blocks with randomized data/strobe/flow control and
// compares the captured DAT0 bit stream against a byte-level reference model.
module tb_sd_dat_blk_tx;
    import sd_dat_pkg::*;

    localparam int BLK     = 512;
    localparam int NBITS   = 1 + 8 * BLK + 16 + 1;
    localparam int MAX_CYC = 40000;

    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] blk_data [BLK];

    always #5 CLK = ~CLK;

    sd_dat_blk_tx_if bus ();

    sd_dat_blk_tx #(.BLK_BYTES(BLK), .CNT_W(12)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-wise CCITT CRC-16 over the whole block, init 0.
    function automatic logic [15:0] crc16_ref();
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 0; i < BLK; i++) begin
            c = c ^ {blk_data[i], 8'h00};
            for (int b = 0; b < 8; b++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < BLK; i++)
            blk_data[i] = (mode == 0) ? 8'hFF : (mode == 1) ? 8'h00 : 8'($urandom_range(0, 255));
    endtask

    task automatic run_block(input string name, input int bper, input int stall_byte,
                             input int stall_cyc, input bit gaps, input int abort_at,
                             input int restart_at, input bit inj, input bit crc_fix_en,
                             input logic [15:0] crc_fix, input bit chk_edges);
        logic exp_q[$];
        logic cap_q[$];
        logic [15:0] crc_m;
        logic [15:0] crc_w;
        int idx = 0, hold = 0, cyc = 0, edges = 0, done_cnt = 0, frozen_err = 0;
        int bit_err = 0, extra_done = 0, busy_after = 0, ncmp;
        bit finished = 0, aborted = 0, seen_hold = 0, restarted = 0;
        bit ben, vld, rdy, hold_b;
        logic out_b, oe_at_done, out_at_done, busy_at_done;

        crc_m = crc16_ref() ^ {15'b0, inj};
        exp_q.push_back(1'b0);
        for (int i = 0; i < BLK; i++)
            for (int b = 7; b >= 0; b--) exp_q.push_back(blk_data[i][b]);
        for (int b = 15; b >= 0; b--) exp_q.push_back(crc_m[b]);
        exp_q.push_back(1'b1);
        oe_at_done = 1'bx; out_at_done = 1'bx; busy_at_done = 1'bx;

        @(negedge CLK);
        bus.start = 1'b1;
`ifdef SD_DAT_TX_CRC_INJ_EN
        bus.crc_inj = inj;
`endif
        @(posedge CLK); #1;
        check_val({name, "_busy_rise"}, 32'(bus.busy), 1);
        @(negedge CLK);
        bus.start = 1'b0;

        while (!finished && !aborted && cyc < MAX_CYC) begin
            ben = (bper == 0) ? ($urandom_range(0, 1) == 1) : ((cyc % bper) == 0);
            if (idx < BLK) begin
                bus.din = blk_data[idx];
                if (stall_byte >= 0 && idx == stall_byte && hold < stall_cyc) begin
                    vld = 1'b0;
                    hold++;
                end else begin
                    vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end else begin
                vld = 1'b0;
            end
            bus.bit_en    = ben;
            bus.din_valid = vld;
            bus.start     = 1'b0;
            if (restart_at >= 0 && idx == restart_at && !restarted) begin
                bus.start = 1'b1;
                restarted = 1'b1;
            end
            rdy    = bus.din_ready;
            hold_b = bus.clk_hold;
            out_b  = bus.dat_out;
            if (abort_at >= 0 && idx == abort_at) begin
                RST = 1'b1;
                #1;
                check_val({name, "_abort_oe"}, 32'(bus.dat_oe), 0);
                check_val({name, "_abort_out"}, 32'(bus.dat_out), 1);
                check_val({name, "_abort_busy"}, 32'(bus.busy), 0);
                check_val({name, "_abort_rdy"}, 32'(bus.din_ready), 0);
                aborted = 1'b1;
            end else begin
                @(posedge CLK); #1;
                cyc++;
                if (vld && rdy) idx++;
                if (ben && !bus.clk_hold && bus.dat_oe) cap_q.push_back(bus.dat_out);
                if (bus.clk_hold) seen_hold = 1'b1;
                if (hold_b && bus.clk_hold && bus.dat_out !== out_b) frozen_err++;
                if (ben && cap_q.size() > 0) edges++;
                if (bus.done) begin
                    done_cnt++;
                    finished     = 1'b1;
                    oe_at_done   = bus.dat_oe;
                    out_at_done  = bus.dat_out;
                    busy_at_done = bus.busy;
                end
                @(negedge CLK);
            end
        end

        bus.din_valid = 1'b0;
        bus.start     = 1'b0;

        if (aborted) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge CLK); #1;
                if (bus.done) done_cnt++;
            end
            check_val({name, "_abort_no_done"}, 32'(done_cnt), 0);
            @(negedge CLK);
            RST = 1'b0;
            return;
        end

        check_val({name, "_done_seen"}, 32'(finished), 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            bus.bit_en = 1'b1;
            @(posedge CLK); #1;
            if (bus.done) extra_done++;
            if (bus.busy) busy_after++;
        end
        check_val({name, "_one_done"}, 32'(extra_done), 0);
        check_val({name, "_idle_after"}, 32'(busy_after), 0);
        check_val({name, "_oe_at_done"}, 32'(oe_at_done), 0);
        check_val({name, "_out_at_done"}, 32'(out_at_done), 1);
        check_val({name, "_busy_at_done"}, 32'(busy_at_done), 0);
        check_val({name, "_nbits"}, 32'(cap_q.size()), 32'(NBITS));

        ncmp = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < ncmp; i++)
            if (cap_q[i] !== exp_q[i]) bit_err++;
        check_val({name, "_bit_errs"}, 32'(bit_err), 0);

        if (cap_q.size() == NBITS) begin
            check_val({name, "_start_bit"}, 32'(cap_q[0]), 0);
            check_val({name, "_end_bit"}, 32'(cap_q[NBITS-1]), 1);
            crc_w = 16'h0000;
            for (int i = 0; i < 16; i++) crc_w = {crc_w[14:0], cap_q[1 + 8 * BLK + i]};
            check_val({name, "_crc"}, 32'(crc_w), crc_fix_en ? 32'(crc_fix) : 32'(crc_m));
        end
        if (chk_edges) check_val({name, "_done_latency"}, 32'(edges - 1), 32'(NBITS));
        if (stall_cyc > 0) begin
            check_val({name, "_clk_hold_seen"}, 32'(seen_hold), 1);
            check_val({name, "_frozen"}, 32'(frozen_err), 0);
        end
    endtask

    initial begin
        RST           = 1'b1;
        bus.bit_en    = 1'b0;
        bus.start     = 1'b0;
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
`ifdef SD_DAT_TX_CRC_INJ_EN
        bus.crc_inj   = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_dat_out", 32'(bus.dat_out), 1);
        check_val("rst_dat_oe", 32'(bus.dat_oe), 0);
        check_val("rst_din_ready", 32'(bus.din_ready), 0);
        check_val("rst_clk_hold", 32'(bus.clk_hold), 0);
        check_val("rst_busy", 32'(bus.busy), 0);
        check_val("rst_done", 32'(bus.done), 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        fill(0);
        run_block("ones", 1, -1, 0, 1'b0, -1, -1, 1'b0, 1'b1, 16'h7FA1, 1'b1);
        fill(1);
        run_block("zeros", 1, -1, 0, 1'b0, -1, -1, 1'b0, 1'b1, 16'h0000, 1'b1);
        fill(0);
        run_block("starve", 4, 100, 100, 1'b0, -1, -1, 1'b0, 1'b1, 16'h7FA1, 1'b0);
        fill(2);
        run_block("abort", 1, -1, 0, 1'b0, 200, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
        fill(0);
        run_block("after_abort", 1, -1, 0, 1'b0, -1, -1, 1'b0, 1'b1, 16'h7FA1, 1'b1);
        fill(2);
        run_block("restart", 1, -1, 0, 1'b0, -1, 50, 1'b0, 1'b0, 16'h0000, 1'b1);
        fill(2);
        run_block("random", 0, -1, 0, 1'b1, -1, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
`ifdef SD_DAT_TX_CRC_INJ_EN
        fill(0);
        run_block("inject", 1, -1, 0, 1'b0, -1, -1, 1'b1, 1'b1, 16'h7FA0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
